// File: rtl/rf_scoreboard.sv
// Register file with two combinational read ports, one write port and a per-register busy scoreboard.
// Define RF_BYPASS_EN to forward the write port onto same-cycle reads.
module rf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_a,
  output logic              busy1,
  output logic              busy2,
  output logic              hazard
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_next_s;
  logic              we_ok_s;
  logic              rsv_ok_s;

  assign we_ok_s  = we  && !((ZERO_REG != 0) && (wa    == {ADDR_W{1'b0}}));
  assign rsv_ok_s = rsv && !((ZERO_REG != 0) && (rsv_a == {ADDR_W{1'b0}}));

  // Busy update: the write retires its producer first, then a reservation (the newer producer) wins.
  always_comb begin
    busy_next_s = busy_r;
    if (we_ok_s) begin
      busy_next_s[wa] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (rsv_ok_s) begin
      busy_next_s[rsv_a] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // Storage and scoreboard state; reset overrides any same-cycle write or reservation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      busy_r <= '0;
    end else begin
      if (we_ok_s) begin
        mem_r[wa] <= wd;
      end
      busy_r <= busy_next_s;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rd_s;
    logic              busy_s;

    assign ra_s = (p == 0) ? ra1 : ra2;

    // Read mux: zero register, optional write forwarding, then stored state.
    always_comb begin
      rd_s   = '0;
      busy_s = 1'b0;
      if ((ZERO_REG != 0) && (ra_s == {ADDR_W{1'b0}})) begin
        rd_s   = '0;
        busy_s = 1'b0;
      end else if (BYPASS && we && (ra_s == wa)) begin
        rd_s   = wd;
        busy_s = rsv && (rsv_a == wa);
      end else begin
        rd_s   = mem_r[ra_s];
        busy_s = busy_r[ra_s];
      end
    end
  end

  assign rd1    = g_port[0].rd_s;
  assign rd2    = g_port[1].rd_s;
  assign busy1  = g_port[0].busy_s;
  assign busy2  = g_port[1].busy_s;
  assign hazard = busy1 | busy2;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios followed by random traffic
// compared against an array-based reference model of the register file and scoreboard.
module tb_rf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          rsv;
  logic [AW-1:0] rsv_a;
  logic          busy1;
  logic          busy2;
  logic          hazard;

  int n_checks;
  int n_errors;

  logic [DW-1:0] m_mem  [32];
  logic          m_busy [32];

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rsv(rsv), .rsv_a(rsv_a), .busy1(busy1), .busy2(busy2), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {busy, data} seen on a read port given the model state and current inputs.
  function automatic logic [DW:0] exp_port(input logic [AW-1:0] ra);
    if (ra == 5'd0) return '0;
    if (BYP && we && (ra == wa)) return {rsv && (rsv_a == wa), wd};
    return {m_busy[ra], m_mem[ra]};
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && wa != 5'd0) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (rsv && rsv_a != 5'd0) m_busy[rsv_a] = 1'b1;
    end
  endtask

  // Compare all outputs mid-cycle, then advance one edge and update the model.
  task automatic step();
    logic [DW:0] e1;
    logic [DW:0] e2;
    @(negedge clk);
    e1 = exp_port(ra1);
    e2 = exp_port(ra2);
    check("rd1",    64'(rd1),    64'(e1[DW-1:0]));
    check("rd2",    64'(rd2),    64'(e2[DW-1:0]));
    check("busy1",  64'(busy1),  64'(e1[DW]));
    check("busy2",  64'(busy2),  64'(e2[DW]));
    check("hazard", 64'(hazard), 64'(e1[DW] | e2[DW]));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; rsv = 1'b0; rsv_a = '0; ra1 = '0; ra2 = '0;
    @(posedge clk);
    model_edge();
    #1;

    // Reset then read
    rst = 1'b0; ra1 = 5'd5; ra2 = 5'd31;
    #2;
    check("rst_rd1", 64'(rd1), 64'd0);
    check("rst_rd2", 64'(rd2), 64'd0);
    check("rst_hazard", 64'(hazard), 64'd0);
    step();

    // Write then read
    we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF; ra1 = 5'd3;
    step();
    we = 1'b0;
    #2;
    check("wr_rd1", 64'(rd1), 64'hDEADBEEF);
    check("wr_busy1", 64'(busy1), 64'd0);
    step();

    // Reserve, observe busy, then retire with a write
    rsv = 1'b1; rsv_a = 5'd7;
    step();
    rsv = 1'b0; ra2 = 5'd7;
    #2;
    check("rsv_busy2", 64'(busy2), 64'd1);
    check("rsv_hazard", 64'(hazard), 64'd1);
    step();
    we = 1'b1; wa = 5'd7; wd = 32'h12;
    step();
    we = 1'b0;
    #2;
    check("retire_busy2", 64'(busy2), 64'd0);
    check("retire_rd2", 64'(rd2), 64'h12);
    step();

    // Same-cycle reserve and write to one register
    rsv = 1'b1; rsv_a = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h55;
    step();
    rsv = 1'b0; we = 1'b0; ra1 = 5'd9;
    #2;
    check("coll_rd1", 64'(rd1), 64'h55);
    check("coll_busy1", 64'(busy1), 64'd1);
    step();

    // Zero register ignores writes and reservations
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; rsv = 1'b1; rsv_a = 5'd0; ra1 = 5'd0;
    step();
    we = 1'b0; rsv = 1'b0;
    #2;
    check("zero_rd1", 64'(rd1), 64'd0);
    check("zero_busy1", 64'(busy1), 64'd0);
    step();

    // Read during write on a reserved register
    rsv = 1'b1; rsv_a = 5'd4;
    step();
    rsv = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'hA5A5A5A5; ra1 = 5'd4;
    #2;
    check("rdw_rd1", 64'(rd1), BYP ? 64'hA5A5A5A5 : 64'd0);
    check("rdw_busy1", 64'(busy1), BYP ? 64'd0 : 64'd1);
    step();

    // Reset drops pending reservations; a later write is ordinary
    we = 1'b0; rsv = 1'b1; rsv_a = 5'd4;
    step();
    rst = 1'b1; rsv_a = 5'd6;
    step();
    rst = 1'b0; rsv = 1'b0; ra1 = 5'd4; ra2 = 5'd6;
    #2;
    check("rstp_busy1", 64'(busy1), 64'd0);
    check("rstp_busy2", 64'(busy2), 64'd0);
    check("rstp_rd1", 64'(rd1), 64'd0);
    step();
    we = 1'b1; wa = 5'd4; wd = 32'h77;
    step();
    we = 1'b0;
    #2;
    check("post_rd1", 64'(rd1), 64'h77);
    check("post_busy1", 64'(busy1), 64'd0);
    step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      we    = $urandom_range(0, 1) == 1;
      wa    = rnd_addr();
      wd    = $urandom;
      rsv   = $urandom_range(0, 2) == 0;
      rsv_a = ($urandom_range(0, 3) == 0) ? wa : rnd_addr();
      ra1   = ($urandom_range(0, 3) == 0) ? wa : rnd_addr();
      ra2   = ($urandom_range(0, 4) == 0) ? ra1 : rnd_addr();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
